// File: rtl/tracker_gen.sv
// tracker_gen: single-clock step tracker with auto-rotating 4-digit BCD display.
//   Tracks total steps, distance, fast seconds in the first WINDOW_SEC seconds
//   and accumulated sustained high-activity time. The metric selected by the
//   current mode is converted to BCD by a sequential double-dabble engine.
// Optional feature: define TRACKER_ZERO_BLANK_EN to blank leading zeros
//   (5'h10) in modes 0, 2 and 3; the least significant digit is never blanked.
// Ports:
//   sys_clk        system clock, all state changes on its rising edge
//   reset          synchronous active-low reset
//   step_in        raw step pulse, asynchronous to sys_clk
//   pps_in         raw 1 Hz square wave, asynchronous to sys_clk
//   mode_hold      1 freezes mode rotation
//   si             total steps exceed DISP_MAX
//   mode           0 steps, 1 distance, 2 fast seconds, 3 high-activity time
//   bcd3..bcd0     display digits, bcd3 most significant
//   bcd_valid      digits reflect the currently selected value
module tracker_gen #(
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned DISP_MAX   = 9999,
    parameter int unsigned HALF_LOG2  = 10,
    parameter int unsigned FAST_THR   = 32,
    parameter int unsigned WINDOW_SEC = 9,
    parameter int unsigned HIGH_THR   = 64,
    parameter int unsigned HIGH_SEC   = 60,
    parameter int unsigned MODE_SEC   = 2
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       step_in,
    input  logic       pps_in,
    input  logic       mode_hold,
    output logic       si,
    output logic [1:0] mode,
    output logic [4:0] bcd3,
    output logic [4:0] bcd2,
    output logic [4:0] bcd1,
    output logic [4:0] bcd0,
    output logic       bcd_valid
);

    localparam int unsigned SRC_W = $clog2(DISP_MAX + 1);
    localparam int unsigned BCD_W = 16;
    localparam int unsigned SC_W  = $clog2(SRC_W + 1);
    localparam int unsigned MS_W  = $clog2(MODE_SEC + 1);
    localparam int unsigned KEY_W = 2 + 1 + SRC_W;
    localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == SAT) ? v : v + CNT_W'(1);
    endfunction

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    function automatic logic [BCD_W-1:0] dd_adj(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Input conditioning: 2-FF synchroniser, edge history, registered strobe.
    logic [2:0] step_sync, pps_sync;
    logic       step_tick, sec_tick;

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            step_sync <= '0;
            pps_sync  <= '0;
            step_tick <= 1'b0;
            sec_tick  <= 1'b0;
        end else begin
            step_sync <= {step_sync[1:0], step_in};
            pps_sync  <= {pps_sync[1:0], pps_in};
            step_tick <= step_sync[1] & ~step_sync[2];
            sec_tick  <= pps_sync[1] & ~pps_sync[2];
        end
    end

    // Metric counters.
    logic [CNT_W-1:0] total, sec_steps, sec_num, fast_cnt, run, high_total;
    logic [CNT_W-1:0] run_next, high_add;
    logic [CNT_W:0]   high_sum;
    logic [MS_W-1:0]  mode_sec;

    always_comb begin
        run_next = (sec_steps >= CNT_W'(HIGH_THR)) ? sat_inc(run) : '0;
        high_sum = {1'b0, high_total} + (CNT_W + 1)'(HIGH_SEC);
        high_add = high_sum[CNT_W] ? SAT : high_sum[CNT_W-1:0];
    end

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            total      <= '0;
            sec_steps  <= '0;
            sec_num    <= '0;
            fast_cnt   <= '0;
            run        <= '0;
            high_total <= '0;
            mode_sec   <= '0;
            mode       <= 2'd0;
            si         <= 1'b0;
        end else begin
            si <= (total > CNT_W'(DISP_MAX));
            if (step_tick) total <= sat_inc(total);
            if (sec_tick) begin
                // A step coinciding with the second boundary belongs to the new second.
                sec_steps <= step_tick ? CNT_W'(1) : '0;
                sec_num   <= sat_inc(sec_num);
                if (sec_num < CNT_W'(WINDOW_SEC) && sec_steps > CNT_W'(FAST_THR) &&
                    fast_cnt < CNT_W'(WINDOW_SEC))
                    fast_cnt <= fast_cnt + CNT_W'(1);
                run <= run_next;
                if (run_next == CNT_W'(HIGH_SEC))
                    high_total <= high_add;
                else if (run_next > CNT_W'(HIGH_SEC))
                    high_total <= sat_inc(high_total);
                if (!mode_hold) begin
                    if (mode_sec >= MS_W'(MODE_SEC - 1)) begin
                        mode     <= mode + 2'd1;
                        mode_sec <= '0;
                    end else begin
                        mode_sec <= mode_sec + MS_W'(1);
                    end
                end
            end else if (step_tick) begin
                sec_steps <= sat_inc(sec_steps);
            end
        end
    end

    // Source selection; the key also covers mode and the half-unit flag so any
    // visible change of the display content forces a fresh conversion.
    logic [CNT_W-1:0] whole_raw, sel;
    logic [6:0]       whole;
    logic             half_lsb;
    logic [SRC_W-1:0] src;
    logic [KEY_W-1:0] key, key_q;
    logic             changed;

    always_comb begin
        whole_raw = total >> (HALF_LOG2 + 1);
        whole     = (whole_raw > CNT_W'(99)) ? 7'd99 : whole_raw[6:0];
        half_lsb  = total[HALF_LOG2];
        case (mode)
            2'd0:    sel = total;
            2'd1:    sel = CNT_W'(whole);
            2'd2:    sel = fast_cnt;
            default: sel = high_total;
        endcase
        src     = (sel > CNT_W'(DISP_MAX)) ? SRC_W'(DISP_MAX) : sel[SRC_W-1:0];
        key     = {mode, (mode == 2'd1) & half_lsb, src};
        changed = (key != key_q);
    end

    // Sequential double-dabble converter.
    conv_state_t            state;
    logic                   dirty;
    logic [SRC_W-1:0]       bin;
    logic [BCD_W-1:0]       bcd_sr;
    logic [SC_W-1:0]        shift_cnt;
    logic [1:0]             conv_mode;
    logic                   conv_frac;
    logic [BCD_W+SRC_W-1:0] dd_next;
    logic [4:0]             d3, d2, d1, d0, fmt3, fmt2, fmt1, fmt0;

    assign dd_next = {dd_adj(bcd_sr), bin} << 1;

    // Final digit formatting, applied when the conversion completes.
    always_comb begin
        d3   = {1'b0, bcd_sr[15:12]};
        d2   = {1'b0, bcd_sr[11:8]};
        d1   = {1'b0, bcd_sr[7:4]};
        d0   = {1'b0, bcd_sr[3:0]};
        fmt3 = d3;
        fmt2 = d2;
        fmt1 = d1;
        fmt0 = d0;
        if (conv_mode == 2'd1) begin
            fmt3 = d1;
            fmt2 = d0;
            fmt1 = 5'h1F;
            fmt0 = conv_frac ? 5'd5 : 5'd0;
        end else begin
`ifdef TRACKER_ZERO_BLANK_EN
            if (d3 == 5'd0) begin
                fmt3 = 5'h10;
                if (d2 == 5'd0) begin
                    fmt2 = 5'h10;
                    if (d1 == 5'd0) fmt1 = 5'h10;
                end
            end
`endif
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            state     <= IDLE;
            dirty     <= 1'b1;
            key_q     <= '0;
            bin       <= '0;
            bcd_sr    <= '0;
            shift_cnt <= '0;
            conv_mode <= 2'd0;
            conv_frac <= 1'b0;
            bcd3      <= 5'd0;
            bcd2      <= 5'd0;
            bcd1      <= 5'd0;
            bcd0      <= 5'd0;
            bcd_valid <= 1'b0;
        end else begin
            key_q <= key;
            if (changed) begin
                dirty     <= 1'b1;
                bcd_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    // LOAD samples the live source, so the pending change is consumed here.
                    if (dirty || changed) begin
                        dirty <= 1'b0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    bin       <= src;
                    bcd_sr    <= '0;
                    shift_cnt <= '0;
                    conv_mode <= mode;
                    conv_frac <= (mode == 2'd1) & half_lsb;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    bcd_sr    <= dd_next[SRC_W +: BCD_W];
                    bin       <= dd_next[SRC_W-1:0];
                    shift_cnt <= shift_cnt + SC_W'(1);
                    if (shift_cnt == SC_W'(SRC_W - 1)) state <= DONE;
                end
                DONE: begin
                    bcd3      <= fmt3;
                    bcd2      <= fmt2;
                    bcd1      <= fmt1;
                    bcd0      <= fmt0;
                    bcd_valid <= !dirty && !changed;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tracker_gen.sv
// Testbench for tracker_gen: directed phases with randomised idle gaps,
// checked against an integer reference model of the tracker metrics.
module tb_tracker_gen;

    localparam int DISP_MAX   = 9999;
    localparam int HALF_LOG2  = 10;
    localparam int FAST_THR   = 32;
    localparam int WINDOW_SEC = 9;
    localparam int HIGH_THR   = 64;
    localparam int HIGH_SEC   = 60;
    localparam int MODE_SEC   = 2;

    logic       sys_clk = 1'b0;
    logic       reset, step_in, pps_in, mode_hold;
    logic       si, bcd_valid;
    logic [1:0] mode;
    logic [4:0] bcd3, bcd2, bcd1, bcd0;

    tracker_gen dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .step_in   (step_in),
        .pps_in    (pps_in),
        .mode_hold (mode_hold),
        .si        (si),
        .mode      (mode),
        .bcd3      (bcd3),
        .bcd2      (bcd2),
        .bcd1      (bcd1),
        .bcd0      (bcd0),
        .bcd_valid (bcd_valid)
    );

    always #5 sys_clk = ~sys_clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    int m_total, m_sec_steps, m_sec_num, m_fast, m_run, m_high, m_mode, m_msec;

    task automatic model_reset();
        m_total = 0; m_sec_steps = 0; m_sec_num = 0; m_fast = 0;
        m_run = 0; m_high = 0; m_mode = 0; m_msec = 0;
    endtask

    task automatic model_second(input bit coincident);
        if (m_sec_num < WINDOW_SEC && m_sec_steps > FAST_THR && m_fast < WINDOW_SEC)
            m_fast++;
        m_sec_num++;
        m_run = (m_sec_steps >= HIGH_THR) ? m_run + 1 : 0;
        if (m_run == HIGH_SEC) m_high += HIGH_SEC;
        else if (m_run > HIGH_SEC) m_high++;
        if (!mode_hold) begin
            m_msec++;
            if (m_msec == MODE_SEC) begin
                m_mode = (m_mode + 1) % 4;
                m_msec = 0;
            end
        end
        m_sec_steps = coincident ? 1 : 0;
    endtask

    task automatic exp_digits(output int e3, output int e2, output int e1, output int e0);
        int v;
        int w;
        if (m_mode == 1) begin
            w  = m_total / (2 ** (HALF_LOG2 + 1));
            if (w > 99) w = 99;
            e3 = w / 10;
            e2 = w % 10;
            e1 = 31;
            e0 = ((m_total / (2 ** HALF_LOG2)) % 2 == 1) ? 5 : 0;
        end else begin
            v  = (m_mode == 0) ? m_total : (m_mode == 2) ? m_fast : m_high;
            if (v > DISP_MAX) v = DISP_MAX;
            e3 = v / 1000;
            e2 = (v / 100) % 10;
            e1 = (v / 10) % 10;
            e0 = v % 10;
`ifdef TRACKER_ZERO_BLANK_EN
            if (e3 == 0) begin
                e3 = 16;
                if (e2 == 0) begin
                    e2 = 16;
                    if (e1 == 0) e1 = 16;
                end
            end
`endif
        end
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_gap();
        repeat ($urandom_range(0, 3)) tick();
    endtask

    task automatic step_pulse();
        step_in = 1'b1;
        tick();
        step_in = 1'b0;
        tick();
        m_total++;
        m_sec_steps++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step_pulse();
    endtask

    // Trailing cycles let the tick reach the counters before mode_hold may change.
    task automatic sec_pulse();
        idle_gap();
        pps_in = 1'b1;
        tick();
        pps_in = 1'b0;
        tick();
        repeat (4) tick();
        model_second(1'b0);
    endtask

    task automatic step_and_sec();
        step_in = 1'b1;
        pps_in  = 1'b1;
        tick();
        step_in = 1'b0;
        pps_in  = 1'b0;
        tick();
        repeat (4) tick();
        model_second(1'b1);
        m_total++;
    endtask

    task automatic rotate_once();
        mode_hold = 1'b0;
        sec_pulse();
        sec_pulse();
        mode_hold = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        reset   = 1'b0;
        step_in = 1'b0;
        pps_in  = 1'b0;
        tick();
        cmp({tag, "_mode"}, 32'(mode), 0);
        cmp({tag, "_si"}, 32'(si), 0);
        cmp({tag, "_valid"}, 32'(bcd_valid), 0);
        cmp({tag, "_digits"}, 32'({bcd3, bcd2, bcd1, bcd0}), 0);
        tick();
        reset = 1'b1;
        model_reset();
    endtask

    task automatic check_display(input string tag);
        int n;
        int e3, e2, e1, e0;
        repeat (6) tick();
        n = 0;
        while (bcd_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        cmp({tag, "_valid"}, 32'(bcd_valid), 1);
        exp_digits(e3, e2, e1, e0);
        cmp({tag, "_mode"}, 32'(mode), 32'(m_mode));
        cmp({tag, "_si"}, 32'(si), (m_total > DISP_MAX) ? 1 : 0);
        cmp({tag, "_bcd3"}, 32'(bcd3), 32'(e3));
        cmp({tag, "_bcd2"}, 32'(bcd2), 32'(e2));
        cmp({tag, "_bcd1"}, 32'(bcd1), 32'(e1));
        cmp({tag, "_bcd0"}, 32'(bcd0), 32'(e0));
    endtask

    initial begin
        reset     = 1'b0;
        step_in   = 1'b0;
        pps_in    = 1'b0;
        mode_hold = 1'b1;
        model_reset();

        // Steps, distance and saturation of the displayed value.
        do_reset("rst_a");
        check_display("zero");
        steps(1234);
        check_display("steps1234");
        steps(3072 - 1234);
        check_display("steps3072");
        rotate_once();
        check_display("dist3072");
        steps(10001 - 3072);
        check_display("dist10001");
        rotate_once();
        check_display("fast_a");
        rotate_once();
        check_display("high_a");
        rotate_once();
        check_display("steps10001");

        // Mode change starts a conversion; reset lands mid-conversion.
        mode_hold = 1'b0;
        sec_pulse();
        sec_pulse();
        mode_hold = 1'b1;
        do_reset("rst_mid");

        // Fast seconds in the initial window.
        for (int s = 1; s <= WINDOW_SEC; s++) begin
            steps((s % 2 == 1) ? 40 : 20);
            sec_pulse();
        end
        for (int s = 0; s < 3; s++) begin
            steps(50);
            sec_pulse();
        end
        rotate_once();
        rotate_once();
        check_display("fast5");

        // Sustained high activity.
        do_reset("rst_c");
        rotate_once();
        rotate_once();
        rotate_once();
        check_display("high0");
        for (int s = 1; s <= 61; s++) begin
            steps(HIGH_THR);
            sec_pulse();
            if (s >= 59) check_display($sformatf("high_s%0d", s));
        end
        steps(10);
        sec_pulse();
        check_display("high_hold");

        // Just below the high threshold never credits time.
        do_reset("rst_d");
        rotate_once();
        rotate_once();
        rotate_once();
        for (int s = 0; s < 70; s++) begin
            steps(HIGH_THR - 1);
            sec_pulse();
        end
        check_display("high_below");

        // Step coincident with the second boundary belongs to the new second.
        do_reset("rst_e");
        rotate_once();
        rotate_once();
        steps(FAST_THR);
        step_and_sec();
        check_display("coin_old");
        steps(FAST_THR);
        sec_pulse();
        check_display("coin_new");

        // Free-running mode rotation.
        do_reset("rst_f");
        mode_hold = 1'b0;
        for (int s = 1; s <= 8; s++) begin
            sec_pulse();
            cmp($sformatf("rot_tick%0d", s), 32'(mode), 32'(m_mode));
        end
        mode_hold = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tracker_gen.md
Name: tracker_gen

Overview:
- Parametrised, single-clock successor of the step tracker.
- Step and 1 Hz inputs are synchronised and edge-detected on sys_clk, so there are no multi-clock always blocks.
- Tracks four metrics:
  - total steps,
  - distance,
  - count of fast seconds in an initial window,
  - accumulated sustained high-activity time.
- An auto-rotating display mode selects one metric, which is converted to BCD by a sequential double-dabble engine and drives the 4-digit seven-segment decoder.

Parameters:
- CNT_W, 20, width of all internal counters; every counter saturates at 2**CNT_W-1.
- DISP_MAX, 9999, largest displayable value; larger values display as DISP_MAX.
- HALF_LOG2, 10, log2 of steps per half distance unit.
- FAST_THR, 32, a second is "fast" if its step count is strictly greater than this.
- WINDOW_SEC, 9, number of seconds after reset in which fast seconds are counted.
- HIGH_THR, 64, a second is "high" if its step count is greater than or equal to this.
- HIGH_SEC, 60, minimum run of consecutive high seconds before run time is credited.
- MODE_SEC, 2, seconds per display mode before auto-advance.

Ports:
- sys_clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- step_in  in  1  raw step pulse, asynchronous to sys_clk.
- pps_in  in  1  raw 1 Hz square wave, asynchronous to sys_clk.
- mode_hold  in  1  1 = freeze mode rotation.
- si  out  1  1 when total steps > DISP_MAX.
- mode  out  2  current mode: 0 steps, 1 distance, 2 fast seconds, 3 high-activity time.
- bcd3,bcd2,bcd1,bcd0  out  5 each  display digits, bcd3 most significant.
- bcd_valid  out  1  1 when the digits reflect the current selected value.

Behaviour:
- **Input conditioning**
  - Each raw input passes through a 2-FF synchroniser plus a rising-edge detector.
  - This yields one-cycle strobes step_tick and sec_tick, 3 cycles after the raw edge.
- **Reset (reset==0 at a clock edge)**
  - All counters and synchroniser flops clear.
  - mode=0, si=0, digits=0, bcd_valid=0, converter idle with a pending start.
- **Total steps:** total +1 per step_tick, saturating. si = (total > DISP_MAX), registered.
- **Distance**
  - half = total >> HALF_LOG2; whole = min(half>>1, 99).
  - Display format: bcd3/bcd2 = tens/units of whole, bcd1 = 5'h1F (underscore), bcd0 = 5 if half[0] else 0.
- **Per-second step count (sec_steps)**
  - step_tick increments it, saturating.
  - On sec_tick, the classification below uses the pre-tick value, then sec_steps clears.
  - If step_tick and sec_tick coincide, sec_steps loads 1: the step belongs to the new second.
- **Window and fast seconds**
  - sec_num increments on each sec_tick, saturating.
  - On sec_tick with sec_num < WINDOW_SEC: fast_cnt += (sec_steps > FAST_THR).
  - fast_cnt never exceeds WINDOW_SEC.
- **High activity**
  - On sec_tick: run_next = (sec_steps >= HIGH_THR) ? run+1 : 0.
  - If run_next == HIGH_SEC, high_total += HIGH_SEC; else if run_next > HIGH_SEC, high_total += 1.
  - run and high_total saturate.
- **Mode rotation**
  - mode_sec counts sec_ticks.
  - When it reaches MODE_SEC and mode_hold==0: mode advances (3 wraps to 0) and mode_sec clears.
  - While mode_hold==1, mode_sec holds.
- **Converter**
  - Source: min(selected value, DISP_MAX); in mode 1 the source is whole.
  - States IDLE -> LOAD -> SHIFT (14 cycles) -> DONE -> IDLE.
  - Output digits are registered at DONE. bcd_valid=1 from DONE until the source next changes.
  - A change of source value or mode sets a dirty flag and drops bcd_valid the next cycle.
  - Conversion starts only from IDLE; a change during SHIFT is serviced by one further conversion after DONE.
  - Latency from a change to valid digits, converter idle: at most 17 cycles.
  - In mode 1, bcd1/bcd0 are overridden as above and bcd3/bcd2 take converter digits 1/0.
- **Reset mid-conversion** aborts the conversion; digits return to 0.

Optional Feature:
- Macro TRACKER_ZERO_BLANK_EN.
- Defined: in modes 0, 2 and 3, leading zero digits above the most significant nonzero digit output 5'h10 (blank); bcd0 is never blanked.
- Mode 1 is unaffected.
- Undefined: leading zeros are shown as 0.

Test Plan:
- Reset low 2 cycles, then 1234 step pulses, mode_hold=1, mode 0 -> digits 1,2,3,4 with bcd_valid=1 within 17 cycles of the last step_tick; si=0.
- 10001 steps -> si=1, mode-0 digits 9,9,9,9; 3072 steps in mode 1 -> 0,1,1F,5.
- First 9 seconds alternate 40/20 steps, then 50 steps per second -> fast_cnt=5 (seconds 1,3,5,7,9), unchanged afterwards.
- 61 consecutive seconds of 64 steps, then 10 steps, mode 3 -> high_total=60 after second 60, 61 after second 61, held at 61; 63 steps for 70 seconds -> 0.
- step_tick coincident with sec_tick -> new-second count=1 and previous classification excludes that step.
- mode_hold=0 for 8 sec_ticks -> mode sequence 0,1,2,3,0; reset low mid-conversion -> digits 0, bcd_valid=0, mode=0 next cycle.
